instr_register_mc: RTL and testbench
====================================

Name: instr_register_mc

Overview:
- Parametrised, multi-cycle successor to the team's instruction register.
- Accepts an opcode plus two signed operands through a ready/valid load port and computes the result with an internal ALU. DIV/MOD use a sequential restoring divider.
- Stores {opcode, operand_a, operand_b, result} into a DEPTH-entry register array at a chosen write address.
- Sits between the instruction-generator testbench/stimulus side and any consumer reading back via read_pointer.

Parameters:
- OP_WIDTH, 32, width of signed operands; result width is 2*OP_WIDTH.
- DEPTH, 32, number of entries; ADDR_W = $clog2(DEPTH), minimum 1.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- load_en  in  1  load request (valid)
- load_ready  out  1  block can accept a load this cycle
- opcode  in  4  opcode_t
- operand_a  in  OP_WIDTH  signed operand A
- operand_b  in  OP_WIDTH  signed operand B
- write_pointer  in  ADDR_W  destination entry for the load
- read_pointer  in  ADDR_W  entry to read back
- rd_opcode  out  4  stored opcode at read_pointer
- rd_operand_a  out  OP_WIDTH  stored A
- rd_operand_b  out  OP_WIDTH  stored B
- rd_result  out  2*OP_WIDTH  stored result
- done  out  1  one-cycle pulse when an entry is written
- done_addr  out  ADDR_W  entry written when done=1

Behaviour:
- Reset (async, active-high):
  - All entries set to opcode ZERO, operands 0, result 0.
  - FSM goes to IDLE; done=0, done_addr=0, load_ready=1.
  - Reset during CALC aborts the operation; no entry is written.
- FSM IDLE -> CALC -> WRITE -> IDLE.
- load_ready is 1 in IDLE and WRITE, 0 in CALC.
- A load is accepted on a clock edge with load_en && load_ready. On acceptance, opcode, operands and write_pointer are latched internally and the FSM enters CALC.
- An acceptance in WRITE goes straight to CALC, so back-to-back throughput is one instruction per 2 cycles for single-cycle ops.
- CALC duration:
  - 1 cycle for ZERO, PASSA, PASSB, ADD, SUB, MULT and unused opcodes 8..15.
  - Exactly OP_WIDTH cycles for DIV/MOD, one quotient bit per cycle, operating on magnitudes with sign fix-up at the end.
- WRITE lasts 1 cycle:
  - done=1 and done_addr = latched pointer.
  - The entry is written on the edge ending WRITE.
- Latency, single-cycle op: accept on edge k, done high in the cycle after edge k+1, entry visible from edge k+2.
- Latency, DIV/MOD: entry visible from edge k+OP_WIDTH+1.
- Result rules, all on a 2*OP_WIDTH signed result, always exact:
  - ZERO = 0.
  - PASSA / PASSB = sign-extended operand.
  - ADD / SUB = sign-extended exact sum/difference; no overflow possible.
  - MULT = full signed product.
  - DIV truncates toward zero. MOST_NEG / -1 yields +2^(OP_WIDTH-1), which is exact in 2W bits.
  - MOD: remainder takes the sign of the dividend.
  - Divide by zero (DIV or MOD with b=0): result 0.
  - Opcodes 8..15: result 0.
- Read port is combinational from the array.
  - A read of the entry being written in the same cycle returns the old contents.
- load_en in CALC is ignored; inputs are not sampled.
- write_pointer wraps naturally. When DEPTH is not a power of two, pointers >= DEPTH are dropped on write (done still pulses) and read as all-zero.

Optional Feature:
- Macro: INSTR_REG_ERR_FLAG_EN.
- Defined: each entry gains an err bit and an output rd_err (1 bit) is added.
  - err=1 on divide by zero or an opcode in 8..15.
  - err is cleared by reset.
  - done_err (1 bit) is added; it accompanies done.
- Undefined: no err storage, no rd_err/done_err ports; result behaviour is unchanged.

Decomposition:
- Shared package instr_register_pkg holds:
  - opcode_t, extended with a localparam count of defined opcodes.
  - Default width/depth constants.
- Operand and result types are derived from parameters inside the module.
- One sub-module: seq_divider (OP_WIDTH parameter).
  - Ports: start, dividend, divisor, busy, valid, quotient, remainder, div_by_zero.
  - Same clk/reset convention as the parent.

Test Plan:
- Reset then read all 32 entries -> opcode ZERO, operands 0, result 0; load_ready=1, done=0.
- Load ADD a=0x7FFFFFFF, b=1, wp=3 -> done after 2 cycles with done_addr=3; read 3 returns result 0x0000_0000_8000_0000.
- Load MULT a=-3, b=0x40000000, wp=31 -> result 0xFFFF_FFFF_4000_0000 (-3*2^30).
- Load DIV a=0x80000000, b=-1 -> load_ready low for 32 cycles, result 0x0000_0000_8000_0000. MOD a=-7, b=2 -> result -1. DIV b=0 -> result 0 (rd_err=1 when INSTR_REG_ERR_FLAG_EN).
- Back-to-back PASSA loads held during WRITE cycles -> one entry per 2 cycles; load_en during a DIV's CALC is ignored (no extra entry written).
- Assert reset at cycle 10 of a DIV -> no done, target entry keeps its reset value, load_ready=1 after reset.

Source files
------------

// File: rtl/instr_register_pkg.sv
// Shared types for the multi-cycle instruction register: opcodes, FSM states, default sizes.
package instr_register_pkg;

    localparam int DEFAULT_OP_WIDTH = 32;
    localparam int DEFAULT_DEPTH    = 32;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    // Encodings at or above this count are reserved and produce a zero result.
    localparam int NUM_OPCODES = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        WRITE = 2'd2
    } state_t;

    function automatic logic is_div_op(input opcode_t op);
        return (op == DIV) || (op == MOD);
    endfunction

    function automatic logic is_defined_op(input opcode_t op);
        return int'(op) < NUM_OPCODES;
    endfunction

endpackage

// File: rtl/instr_register_mc_seq_divider.sv
// Sequential restoring divider on operand magnitudes, signs restored on the outputs.
// Latency: start edge does the first bit; valid pulses in the cycle after the last of OP_WIDTH iterations.
// Backpressure: none; the parent must not assert start while busy.
module seq_divider
    import instr_register_pkg::*;
#(
    parameter int OP_WIDTH = DEFAULT_OP_WIDTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [OP_WIDTH-1:0] dividend,
    input  logic [OP_WIDTH-1:0] divisor,
    output logic                busy,
    output logic                valid,
    output logic [OP_WIDTH:0]   quotient,
    output logic [OP_WIDTH-1:0] remainder,
    output logic                div_by_zero
);

    localparam int CNT_W = $clog2(OP_WIDTH + 1);
    localparam logic [CNT_W-1:0] FIRST_CNT = CNT_W'(OP_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [OP_WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                q_neg_q, r_neg_q;

    logic [OP_WIDTH-1:0] dvd_mag, dvs_mag;
    logic [OP_WIDTH-1:0] src_rem, src_quo, src_dvs;
    logic [OP_WIDTH-1:0] step_rem, step_quo;
    logic [OP_WIDTH:0]   rem_shift, diff;

    // The start cycle feeds fresh magnitudes straight into the step logic, so
    // the first quotient bit is produced on the same edge that loads the operands.
    always_comb begin
        dvd_mag   = dividend[OP_WIDTH-1] ? -dividend : dividend;
        dvs_mag   = divisor[OP_WIDTH-1]  ? -divisor  : divisor;
        src_rem   = start ? '0      : rem_q;
        src_quo   = start ? dvd_mag : quo_q;
        src_dvs   = start ? dvs_mag : dvs_q;
        rem_shift = {src_rem, src_quo[OP_WIDTH-1]};
        diff      = rem_shift - {1'b0, src_dvs};
        step_rem  = diff[OP_WIDTH] ? rem_shift[OP_WIDTH-1:0] : diff[OP_WIDTH-1:0];
        step_quo  = {src_quo[OP_WIDTH-2:0], ~diff[OP_WIDTH]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            busy        <= 1'b0;
            valid       <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (start) begin
                rem_q       <= step_rem;
                quo_q       <= step_quo;
                dvs_q       <= dvs_mag;
                cnt_q       <= FIRST_CNT;
                busy        <= (FIRST_CNT != '0);
                valid       <= (FIRST_CNT == '0);
                q_neg_q     <= dividend[OP_WIDTH-1] ^ divisor[OP_WIDTH-1];
                r_neg_q     <= dividend[OP_WIDTH-1];
                div_by_zero <= (divisor == '0);
            end else if (busy) begin
                rem_q <= step_rem;
                quo_q <= step_quo;
                cnt_q <= cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    busy  <= 1'b0;
                    valid <= 1'b1;
                end
            end
        end
    end

    // Quotient carries one extra bit so MOST_NEG / -1 stays representable.
    assign quotient  = q_neg_q ? -{1'b0, quo_q} : {1'b0, quo_q};
    assign remainder = r_neg_q ? -rem_q : rem_q;

endmodule

// File: rtl/instr_register_mc.sv
// Instruction register with ALU: latches opcode/operands, computes an exact 2W result, stores it per entry.
// Latency: accept to entry visible in 2 edges (single-cycle ops) or OP_WIDTH+1 edges (DIV/MOD).
// Backpressure: load_ready drops for the whole CALC phase and load_en is ignored there.
// Optional INSTR_REG_ERR_FLAG_EN adds a per-entry err bit with rd_err and done_err outputs.
module instr_register_mc
    import instr_register_pkg::*;
#(
    parameter  int OP_WIDTH = DEFAULT_OP_WIDTH,
    parameter  int DEPTH    = DEFAULT_DEPTH,
    localparam int ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load_en,
    output logic                         load_ready,
    input  opcode_t                      opcode,
    input  logic signed [OP_WIDTH-1:0]   operand_a,
    input  logic signed [OP_WIDTH-1:0]   operand_b,
    input  logic [ADDR_W-1:0]            write_pointer,
    input  logic [ADDR_W-1:0]            read_pointer,
    output opcode_t                      rd_opcode,
    output logic signed [OP_WIDTH-1:0]   rd_operand_a,
    output logic signed [OP_WIDTH-1:0]   rd_operand_b,
    output logic signed [2*OP_WIDTH-1:0] rd_result,
    output logic                         done,
    output logic [ADDR_W-1:0]            done_addr
`ifdef INSTR_REG_ERR_FLAG_EN
    ,
    output logic                         rd_err,
    output logic                         done_err
`endif
);

    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    typedef struct packed {
        opcode_t                   opcode;
        logic [OP_WIDTH-1:0]       operand_a;
        logic [OP_WIDTH-1:0]       operand_b;
        logic [2*OP_WIDTH-1:0]     result;
`ifdef INSTR_REG_ERR_FLAG_EN
        logic                      err;
`endif
    } entry_t;

    entry_t mem [DEPTH];
    entry_t wr_entry, rd_entry;

    state_t              state_q, state_d;
    opcode_t             op_q;
    logic [OP_WIDTH-1:0] a_q, b_q;
    logic [ADDR_W-1:0]   wp_q;

    logic                accept, div_start;
    logic                div_busy, div_valid, div_by_zero;
    logic [OP_WIDTH:0]   div_quo;
    logic [OP_WIDTH-1:0] div_rem;
    logic [2*OP_WIDTH-1:0] a_ext, b_ext, result_c;
    logic                wp_in_range, rp_in_range;

    assign load_ready = (state_q != CALC) && !div_busy;
    assign accept     = load_en && load_ready;
    assign div_start  = accept && is_div_op(opcode);

    seq_divider #(.OP_WIDTH(OP_WIDTH)) u_div (
        .clk         (clk),
        .reset       (reset),
        .start       (div_start),
        .dividend    (operand_a),
        .divisor     (operand_b),
        .busy        (div_busy),
        .valid       (div_valid),
        .quotient    (div_quo),
        .remainder   (div_rem),
        .div_by_zero (div_by_zero)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = CALC;
            CALC:    if (!is_div_op(op_q) || div_valid) state_d = WRITE;
            WRITE:   state_d = accept ? CALC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= ZERO;
            a_q     <= '0;
            b_q     <= '0;
            wp_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q <= opcode;
                a_q  <= operand_a;
                b_q  <= operand_b;
                wp_q <= write_pointer;
            end
        end
    end

    // Operands are sign-extended to 2W first, so ADD/SUB/MULT are exact by construction.
    always_comb begin
        a_ext    = {{OP_WIDTH{a_q[OP_WIDTH-1]}}, a_q};
        b_ext    = {{OP_WIDTH{b_q[OP_WIDTH-1]}}, b_q};
        result_c = '0;
        case (op_q)
            PASSA:   result_c = a_ext;
            PASSB:   result_c = b_ext;
            ADD:     result_c = a_ext + b_ext;
            SUB:     result_c = a_ext - b_ext;
            MULT:    result_c = a_ext * b_ext;
            DIV:     if (!div_by_zero) result_c = {{(OP_WIDTH-1){div_quo[OP_WIDTH]}}, div_quo};
            MOD:     if (!div_by_zero) result_c = {{OP_WIDTH{div_rem[OP_WIDTH-1]}}, div_rem};
            default: result_c = '0;
        endcase
    end

    always_comb begin
        wr_entry           = '0;
        wr_entry.opcode    = op_q;
        wr_entry.operand_a = a_q;
        wr_entry.operand_b = b_q;
        wr_entry.result    = result_c;
`ifdef INSTR_REG_ERR_FLAG_EN
        wr_entry.err       = (is_div_op(op_q) && div_by_zero) || !is_defined_op(op_q);
`endif
    end

    assign wp_in_range = ({1'b0, wp_q} < DEPTH_LIM);
    assign rp_in_range = ({1'b0, read_pointer} < DEPTH_LIM);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (state_q == WRITE && wp_in_range) begin
            mem[wp_q] <= wr_entry;
        end
    end

    assign rd_entry     = rp_in_range ? mem[read_pointer] : '0;
    assign rd_opcode    = rd_entry.opcode;
    assign rd_operand_a = rd_entry.operand_a;
    assign rd_operand_b = rd_entry.operand_b;
    assign rd_result    = rd_entry.result;

    assign done      = (state_q == WRITE);
    assign done_addr = done ? wp_q : '0;

`ifdef INSTR_REG_ERR_FLAG_EN
    assign rd_err   = rd_entry.err;
    assign done_err = done && wr_entry.err;
`endif

endmodule

// File: tb/tb_instr_register_mc.sv
// Bench for instr_register_mc: table of loads checked through a scoreboard on done, plus corner sequences.
module tb_instr_register_mc;
    import instr_register_pkg::*;

    localparam int W  = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          load_en = 1'b0;
    logic          load_ready, done;
    opcode_t       opcode = ZERO;
    opcode_t       rd_opcode;
    logic [W-1:0]  operand_a = '0, operand_b = '0;
    logic [W-1:0]  rd_operand_a, rd_operand_b;
    logic [2*W-1:0] rd_result;
    logic [AW-1:0] write_pointer = '0, read_pointer, done_addr;
    logic [AW-1:0] main_rp = '0, mon_rp = '0;
    logic          mon_active = 1'b0, chk_pend = 1'b0;
`ifdef INSTR_REG_ERR_FLAG_EN
    logic          rd_err, done_err;
`endif

    int errs = 0;
    int checks = 0;

    typedef struct {
        logic [3:0]     op;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [AW-1:0]  wp;
        logic [2*W-1:0] res;
        logic           err;
    } vec_t;

    vec_t exp_q[$];
    vec_t pend;

    always #5 clk = ~clk;

    assign read_pointer = mon_active ? mon_rp : main_rp;

    instr_register_mc dut (
        .clk           (clk),
        .reset         (reset),
        .load_en       (load_en),
        .load_ready    (load_ready),
        .opcode        (opcode),
        .operand_a     (operand_a),
        .operand_b     (operand_b),
        .write_pointer (write_pointer),
        .read_pointer  (read_pointer),
        .rd_opcode     (rd_opcode),
        .rd_operand_a  (rd_operand_a),
        .rd_operand_b  (rd_operand_b),
        .rd_result     (rd_result),
        .done          (done),
        .done_addr     (done_addr)
`ifdef INSTR_REG_ERR_FLAG_EN
        ,
        .rd_err        (rd_err),
        .done_err      (done_err)
`endif
    );

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errs++;
        $display("FAIL %s: timed out", name);
    endtask

    function automatic logic [159:0] cur_entry();
        return {28'b0, rd_opcode, rd_operand_a, rd_operand_b, rd_result};
    endfunction

    function automatic logic [159:0] vec_entry(input vec_t v);
        return {28'b0, v.op, v.a, v.b, v.res};
    endfunction

    task automatic check_zero(input string name);
        check(name, cur_entry(), 160'(0));
`ifdef INSTR_REG_ERR_FLAG_EN
        check({name, "_err"}, 160'(rd_err), 160'(0));
`endif
    endtask

    task automatic present(input vec_t v);
        opcode        = opcode_t'(v.op);
        operand_a     = v.a;
        operand_b     = v.b;
        write_pointer = v.wp;
        load_en       = 1'b1;
    endtask

    task automatic wait_ready();
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (load_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout("wait_load_ready");
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0 && !chk_pend) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) timeout("drain_scoreboard");
    endtask

    // Scoreboard: each done pops the next expected load, then the entry is read back one cycle later.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_pend) begin
                check($sformatf("entry[%0d]", pend.wp), cur_entry(), vec_entry(pend));
`ifdef INSTR_REG_ERR_FLAG_EN
                check($sformatf("rd_err[%0d]", pend.wp), 160'(rd_err), 160'(pend.err));
`endif
                chk_pend   = 1'b0;
                mon_active = 1'b0;
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL unexpected_done: addr %0d with nothing pending", done_addr);
                end else begin
                    pend = exp_q.pop_front();
                    check("done_addr", 160'(done_addr), 160'(pend.wp));
`ifdef INSTR_REG_ERR_FLAG_EN
                    check("done_err", 160'(done_err), 160'(pend.err));
`endif
                    mon_rp     = pend.wp;
                    mon_active = 1'b1;
                    chk_pend   = 1'b1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[16];
        vec_t bb[4];
        vec_t dv, ign;
        int   n, low, dcnt, sent;
        bit   got;

        vecs[0]  = '{4'd3, 32'h7FFF_FFFF, 32'h0000_0001, 5'd3,  64'h0000_0000_8000_0000, 1'b0};
        vecs[1]  = '{4'd5, 32'hFFFF_FFFD, 32'h4000_0000, 5'd31, 64'hFFFF_FFFF_4000_0000, 1'b0};
        vecs[2]  = '{4'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5,  64'h0000_0000_8000_0000, 1'b0};
        vecs[3]  = '{4'd7, 32'hFFFF_FFF9, 32'h0000_0002, 5'd6,  64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[4]  = '{4'd6, 32'h0000_0064, 32'h0000_0000, 5'd7,  64'h0,                   1'b1};
        vecs[5]  = '{4'd4, 32'h8000_0000, 32'h0000_0001, 5'd8,  64'hFFFF_FFFF_7FFF_FFFF, 1'b0};
        vecs[6]  = '{4'd1, 32'hFFFF_FFFE, 32'h0000_1234, 5'd9,  64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
        vecs[7]  = '{4'd2, 32'h0000_0005, 32'h0000_0007, 5'd10, 64'h7,                   1'b0};
        vecs[8]  = '{4'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd11, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0};
        vecs[9]  = '{4'd7, 32'h0000_0007, 32'hFFFF_FFFE, 5'd12, 64'h1,                   1'b0};
        vecs[10] = '{4'd11, 32'h0000_0005, 32'h0000_0006, 5'd13, 64'h0,                  1'b1};
        vecs[11] = '{4'd0, 32'h0000_0005, 32'h0000_0006, 5'd14, 64'h0,                   1'b0};
        vecs[12] = '{4'd5, 32'h8000_0000, 32'h8000_0000, 5'd15, 64'h4000_0000_0000_0000, 1'b0};
        vecs[13] = '{4'd7, 32'h0000_0005, 32'h0000_0000, 5'd16, 64'h0,                   1'b1};
        vecs[14] = '{4'd6, 32'h7FFF_FFFF, 32'h0000_0010, 5'd17, 64'h0000_0000_07FF_FFFF, 1'b0};
        vecs[15] = '{4'd8, 32'h0000_0001, 32'h0000_0001, 5'd18, 64'h0,                   1'b1};
        for (int i = 0; i < 4; i++)
            bb[i] = '{4'd1, 32'h1000 + i, 32'hDEAD, 5'(20 + i), {32'h0, 32'h1000 + i}, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_load_ready", 160'(load_ready), 160'(1));
        check("reset_done", 160'(done), 160'(0));
        check("reset_done_addr", 160'(done_addr), 160'(0));
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            main_rp = AW'(i);
            #1;
            check_zero($sformatf("reset_entry[%0d]", i));
        end

        // Table of single loads with latency and CALC-length checks
        for (int i = 0; i < 16; i++) begin
            wait_ready();
            present(vecs[i]);
            exp_q.push_back(vecs[i]);
            n = 0; low = 0; got = 1'b0;
            for (int c = 1; c <= 60; c++) begin
                @(negedge clk);
                load_en = 1'b0;
                if (!load_ready) low++;
                if (done) begin
                    n = c;
                    got = 1'b1;
                    break;
                end
            end
            if (!got) timeout($sformatf("done_vec%0d", i));
            else begin
                check($sformatf("latency_vec%0d", i), 160'(n),
                      160'((vecs[i].op == 4'd6 || vecs[i].op == 4'd7) ? W + 1 : 2));
                check($sformatf("busy_cycles_vec%0d", i), 160'(low),
                      160'((vecs[i].op == 4'd6 || vecs[i].op == 4'd7) ? W : 1));
            end
            drain();
        end
        main_rp = 5'd3;
        #1;
        check("entry3_retained", cur_entry(), vec_entry(vecs[0]));

        // Back-to-back PASSA loads accepted in WRITE: one entry every 2 cycles
        @(negedge clk);
        present(bb[0]);
        exp_q.push_back(bb[0]);
        sent = 1; dcnt = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (done) dcnt++;
            if (load_ready && sent < 4) begin
                present(bb[sent]);
                exp_q.push_back(bb[sent]);
                sent++;
            end else if (!load_ready && sent == 4) begin
                load_en = 1'b0;
            end
        end
        load_en = 1'b0;
        check("b2b_done_count", 160'(dcnt), 160'(4));
        drain();

        // load_en held during a DIV's CALC must not create an entry
        dv  = '{4'd6, 32'd1000, 32'd7, 5'd25, 64'd142, 1'b0};
        ign = '{4'd1, 32'h55, 32'h0, 5'd26, 64'h55, 1'b0};
        wait_ready();
        present(dv);
        exp_q.push_back(dv);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            present(ign);
            if (c == 10) load_en = 1'b0;
        end
        drain();
        main_rp = 5'd26;
        #1;
        check_zero("ignored_entry26");

        // Reset in the 10th CALC cycle of a DIV aborts it
        dv = '{4'd6, 32'h1234_5678, 32'd3, 5'd27, 64'h0, 1'b0};
        wait_ready();
        present(dv);
        @(negedge clk);
        load_en = 1'b0;
        repeat (9) @(negedge clk);
        check("mid_div_ready_low", 160'(load_ready), 160'(0));
        reset = 1'b1;
        #1;
        check("abort_load_ready", 160'(load_ready), 160'(1));
        check("abort_done", 160'(done), 160'(0));
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_reset_load_ready", 160'(load_ready), 160'(1));
        repeat (40) @(negedge clk);
        main_rp = 5'd27;
        #1;
        check_zero("aborted_entry27");
        main_rp = 5'd3;
        #1;
        check_zero("cleared_entry3");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
